inst_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC, fetches 32-bit words from instruction ROM over a req/ack handshake,

---
 rtl/inst_fetch.sv | 181 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches from instruction ROM over req/ack, hands
// {inst, pc, pc+4} to decode over valid/ready. Optional macro FETCH_ALIGN_CHECK_EN adds ERR state.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_ack,
  input  logic [31:0] irom_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StHold  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [1:0] StErr   = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_pc4_q, inst_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] rpc;
  logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err_q, fetch_err_d;
  // A misaligned redirect seen while a request is outstanding: enter ERR once it drains.
  logic        err_pend_q, err_pend_d;

  assign rpc        = redirect_pc;
  assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign fetch_err  = fetch_err_q;
`else
  logic unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign rpc            = {redirect_pc[31:2], 2'b00};
  assign misaligned     = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_pc4_d = inst_pc4_q;
    valid_d    = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_err_d = fetch_err_q | misaligned;
    err_pend_d  = err_pend_q;
`endif
    case (state_q)
      StFetch: begin
        if (redirect_valid) begin
          if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (irom_ack) begin
              state_d = StErr;
            end else begin
              state_d    = StDrain;
              err_pend_d = 1'b1;
            end
`endif
          end else if (irom_ack) begin
            pc_d = rpc;
          end else begin
            // Request is in flight; keep addr stable and remember the target.
            pend_pc_d = rpc;
            state_d   = StDrain;
          end
        end else if (irom_ack) begin
          inst_d     = irom_rdata;
          inst_pc_d  = pc_q;
          inst_pc4_d = pc_q + 32'd4;
          valid_d    = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
            state_d = StErr;
`endif
          end else begin
            pc_d    = rpc;
            state_d = StFetch;
          end
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (redirect_valid && !misaligned) begin
          pend_pc_d = rpc;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        if (misaligned) begin
          err_pend_d = 1'b1;
        end
        if (irom_ack) begin
          if (err_pend_q || misaligned) begin
            state_d = StErr;
          end else begin
            pc_d    = redirect_valid ? rpc : pend_pc_q;
            state_d = StFetch;
          end
        end
`else
        if (irom_ack) begin
          pc_d    = redirect_valid ? rpc : pend_pc_q;
          state_d = StFetch;
        end
`endif
      end
`ifdef FETCH_ALIGN_CHECK_EN
      StErr: begin
        valid_d = 1'b0;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'd0;
      inst_q     <= NOP_INST;
      inst_pc_q  <= 32'd0;
      inst_pc4_q <= 32'd0;
      valid_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q <= 1'b0;
      err_pend_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_pc4_q <= inst_pc4_d;
      valid_q    <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q <= fetch_err_d;
      err_pend_q  <= err_pend_d;
`endif
    end
  end

  // pc_q is untouched during DRAIN, so the outstanding address stays stable.
  assign irom_req   = ~cpu_rst & ((state_q == StFetch) | (state_q == StDrain));
  assign irom_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = valid_q ? inst_q : NOP_INST;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc4_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch, plus hand sequences for misaligned redirect
// and PC wraparound (second instance with RESET_PC = 0xFFFF_FFFC).
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        irom_req, irom_ack, inst_valid, inst_ready, redirect_valid, fetch_err;
  logic [31:0] irom_addr, irom_rdata, inst, inst_pc, inst_pc4, redirect_pc;

  logic        w_req, w_ack, w_valid, w_ready, w_err;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 cpu_clk = ~cpu_clk;

  inst_fetch u_dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .irom_req(irom_req), .irom_addr(irom_addr), .irom_ack(irom_ack), .irom_rdata(irom_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_pc4(inst_pc4), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .irom_req(w_req), .irom_addr(w_addr), .irom_ack(w_ack), .irom_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(w_ready), .inst(w_inst), .inst_pc(w_pc),
    .inst_pc4(w_pc4), .redirect_valid(1'b0), .redirect_pc(32'd0),
    .fetch_err(w_err)
  );

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        ready, rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst, e_pc, e_pc4;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic ready, logic rv,
                              logic [31:0] rpc, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_inst, logic [31:0] e_pc,
                              logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_pc4 = e_pc4;
    return v;
  endfunction

  // Address is only compared while a request is expected.
  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc,
                       input logic [31:0] e_pc4, input logic e_err);
    logic ok;
    ok = (irom_req === e_req) && (!e_req || irom_addr === e_addr) && (inst_valid === e_valid)
         && (inst === e_inst) && (inst_pc === e_pc) && (inst_pc4 === e_pc4)
         && (fetch_err === e_err);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got req=%b addr=%h valid=%b inst=%h pc=%h pc4=%h err=%b, want req=%b addr=%h valid=%b inst=%h pc=%h pc4=%h err=%b",
               name, irom_req, irom_addr, inst_valid, inst, inst_pc, inst_pc4, fetch_err,
               e_req, e_addr, e_valid, e_inst, e_pc, e_pc4, e_err);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic ready, input logic rv, input logic [31:0] rpc);
    cpu_rst = rst; irom_ack = ack; irom_rdata = rdata;
    inst_ready = ready; redirect_valid = rv; redirect_pc = rpc;
  endtask

  initial begin
    //               rst ack rdata         rdy rv  rpc        req addr       vld inst          pc         pc4
    vecs[0]  = mk(0, 1, 32'hA000_0000, 1, 0, 0,          1, 32'h0,      0, NOP,          32'h0,     32'h4 - 4);
    vecs[1]  = mk(0, 0, 0,             1, 0, 0,          0, 0,          1, 32'hA000_0000, 32'h0,    32'h4);
    vecs[2]  = mk(0, 1, 32'hA111_1111, 1, 0, 0,          1, 32'h4,      0, NOP,          32'h0,     32'h4);
    vecs[3]  = mk(0, 0, 0,             1, 0, 0,          0, 0,          1, 32'hA111_1111, 32'h4,    32'h8);
    vecs[4]  = mk(0, 1, 32'hA222_2222, 0, 0, 0,          1, 32'h8,      0, NOP,          32'h4,     32'h8);
    for (int k = 5; k <= 10; k++)
      vecs[k] = mk(0, 0, 0, (k == 10), 0, 0,           0, 0,          1, 32'hA222_2222, 32'h8,    32'hC);
    vecs[11] = mk(0, 0, 0,             0, 0, 0,          1, 32'hC,      0, NOP,          32'h8,     32'hC);
    vecs[12] = mk(0, 0, 0,             0, 1, 32'h100,    1, 32'hC,      0, NOP,          32'h8,     32'hC);
    vecs[13] = mk(0, 0, 0,             0, 0, 0,          1, 32'hC,      0, NOP,          32'h8,     32'hC);
    vecs[14] = mk(0, 1, 32'hDEAD_DEAD, 1, 0, 0,          1, 32'hC,      0, NOP,          32'h8,     32'hC);
    vecs[15] = mk(0, 1, 32'hB000_0000, 0, 0, 0,          1, 32'h100,    0, NOP,          32'h8,     32'hC);
    vecs[16] = mk(0, 0, 0,             1, 1, 32'h40,     0, 0,          1, 32'hB000_0000, 32'h100,  32'h104);
    vecs[17] = mk(0, 0, 0,             0, 0, 0,          1, 32'h40,     0, NOP,          32'h100,   32'h104);
    vecs[18] = mk(0, 0, 0,             0, 1, 32'h200,    1, 32'h40,     0, NOP,          32'h100,   32'h104);
    vecs[19] = mk(0, 0, 0,             0, 1, 32'h300,    1, 32'h40,     0, NOP,          32'h100,   32'h104);
    vecs[20] = mk(0, 1, 32'hDEAD_0001, 0, 0, 0,          1, 32'h40,     0, NOP,          32'h100,   32'h104);
    vecs[21] = mk(0, 1, 32'hC000_0000, 1, 0, 0,          1, 32'h300,    0, NOP,          32'h100,   32'h104);
    vecs[22] = mk(0, 0, 0,             1, 0, 0,          0, 0,          1, 32'hC000_0000, 32'h300,  32'h304);
    vecs[23] = mk(0, 1, 32'hBAD0_BAD0, 0, 1, 32'h80,     1, 32'h304,    0, NOP,          32'h300,   32'h304);
    vecs[24] = mk(0, 1, 32'hD000_0000, 0, 0, 0,          1, 32'h80,     0, NOP,          32'h300,   32'h304);
    vecs[25] = mk(0, 0, 0,             0, 1, 32'h500,    0, 0,          1, 32'hD000_0000, 32'h80,   32'h84);
    vecs[26] = mk(0, 1, 32'hE000_0000, 1, 0, 0,          1, 32'h500,    0, NOP,          32'h80,    32'h84);
    vecs[27] = mk(0, 0, 0,             1, 0, 0,          0, 0,          1, 32'hE000_0000, 32'h500,  32'h504);
    vecs[28] = mk(0, 0, 0,             0, 1, 32'h600,    1, 32'h504,    0, NOP,          32'h500,   32'h504);
    vecs[29] = mk(0, 1, 32'hDEAD_0002, 0, 1, 32'h700,    1, 32'h504,    0, NOP,          32'h500,   32'h504);
    vecs[30] = mk(0, 1, 32'hF000_0000, 0, 0, 0,          1, 32'h700,    0, NOP,          32'h500,   32'h504);
    vecs[31] = mk(0, 0, 0,             0, 0, 0,          0, 0,          1, 32'hF000_0000, 32'h700,  32'h704);
    vecs[32] = mk(1, 0, 0,             0, 0, 0,          0, 0,          1, 32'hF000_0000, 32'h700,  32'h704);
    vecs[33] = mk(0, 0, 0,             0, 0, 0,          1, 32'h0,      0, NOP,          32'h0,     32'h0);

    drive(1, 0, 0, 0, 0, 0);
    w_ack = 1'b0; w_ready = 1'b0; w_rdata = 32'd0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk); #1;
    check("reset", 0, 0, 0, NOP, 32'h0, 32'h0, 0);

    for (int i = 0; i < 34; i++) begin
      @(negedge cpu_clk);
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
            vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_pc4, 1'b0);
    end

    // Misaligned redirect 0x102 while a request is outstanding.
    @(negedge cpu_clk);
    drive(0, 0, 0, 0, 1, 32'h102); #1;
    check("mis_req", 1, 32'h0, 0, NOP, 32'h0, 32'h0, 0);
    @(negedge cpu_clk);
    drive(0, 1, 32'hBEEF_BEEF, 0, 0, 0); #1;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_drain", 1, 32'h0, 0, NOP, 32'h0, 32'h0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge cpu_clk);
      drive(0, 1, 32'h1234_0000, 1, 1, 32'h200); #1;
      check($sformatf("mis_err%0d", k), 0, 0, 0, NOP, 32'h0, 32'h0, 1);
    end
`else
    check("mis_drain", 1, 32'h0, 0, NOP, 32'h0, 32'h0, 0);
    @(negedge cpu_clk);
    drive(0, 0, 0, 0, 0, 0); #1;
    check("mis_fetch", 1, 32'h100, 0, NOP, 32'h0, 32'h0, 0);
`endif
    @(negedge cpu_clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge cpu_clk);
    drive(0, 0, 0, 0, 0, 0); #1;
    check("mis_reset", 1, 32'h0, 0, NOP, 32'h0, 32'h0, 0);

    // PC wraparound on the second instance.
    @(negedge cpu_clk);
    w_ack = 1'b1; w_rdata = 32'h1234_5678; w_ready = 1'b0; #1;
    check_bit("wrap_req0", w_req, 1'b1);
    check_word("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge cpu_clk);
    w_ack = 1'b0; w_ready = 1'b1; #1;
    check_bit("wrap_valid", w_valid, 1'b1);
    check_word("wrap_inst", w_inst, 32'h1234_5678);
    check_word("wrap_pc4", w_pc4, 32'h0000_0000);
    @(negedge cpu_clk);
    w_ready = 1'b0; #1;
    check_bit("wrap_req1", w_req, 1'b1);
    check_word("wrap_addr1", w_addr, 32'h0000_0000);
    check_bit("wrap_err", w_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
